// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: arbiter states and data-access size encodings shared by mem_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, DBUS, FBUS} arb_state_t;
   localparam logic [1:0] LS_WORD = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_BYTE = 2'b10;
   localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_arbiter_be_gen.sv
// mem_be_gen: byte enables and lane-replicated store data for a data-port access
module mem_be_gen
   import mem_arb_pkg::*;
(
   input  logic [1:0]  ls,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] bus_wdata
);
   // size 11 falls through to a full-word access
   assign be = ls == LS_WORD ? BE_WORD :
               ls == LS_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
               ls == LS_BYTE ? 4'b0001 << addr : BE_WORD;
   assign bus_wdata = ls == LS_HALF ? {2{wdata[15:0]}} :
                      ls == LS_BYTE ? {4{wdata[7:0]}} : wdata;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports, data first.
// Define MEM_ARB_PERF_EN to add saturating stall-cycle counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_ls,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_dstall_cnt,
   output logic [31:0]       perf_istall_cnt
`endif
);
   arb_state_t state, nxt;
   logic dm_done, if_done, advance;
   logic [3:0] be;
   logic [DATA_W-1:0] wd;
   logic unused_addr_bits;
   assign unused_addr_bits = ^if_addr[1:0];
   mem_be_gen u_be (.ls(dm_ls), .addr(dm_addr[1:0]), .wdata(dm_wdata), .be(be), .bus_wdata(wd));
   assign dm_stall = dm_req & ~dm_done;
   assign if_stall = if_req & ~if_done;
   assign advance  = ~dm_stall & ~if_stall;
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = dm_stall ? DBUS : if_stall ? FBUS : IDLE;
         DBUS:    nxt = mem_ack ? (if_stall ? FBUS : IDLE) : DBUS;
         FBUS:    nxt = mem_ack ? (dm_stall ? DBUS : IDLE) : FBUS;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dm_done   <= 1'b0;
         if_done   <= 1'b0;
         dm_rdata  <= '0;
         if_rdata  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= nxt;
         // a completion wins over a same-cycle advance so a dropped request still records done
         dm_done <= (state == DBUS && mem_ack) ? 1'b1 : advance ? 1'b0 : dm_done;
         if_done <= (state == FBUS && mem_ack) ? 1'b1 : advance ? 1'b0 : if_done;
         if (state == DBUS && mem_ack) dm_rdata <= mem_rdata;
         if (state == FBUS && mem_ack) if_rdata <= mem_rdata;
         if (nxt == DBUS && state != DBUS) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= be;
            mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wd;
         end else if (nxt == FBUS && state != FBUS) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= BE_WORD;
            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= '0;
         end else if (nxt == IDLE) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
         end
      end
   end
`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_dstall_cnt <= '0;
         perf_istall_cnt <= '0;
      end else begin
         perf_dstall_cnt <= (dm_stall && perf_dstall_cnt != '1) ? perf_dstall_cnt + 32'd1 : perf_dstall_cnt;
         perf_istall_cnt <= (if_stall && perf_istall_cnt != '1) ? perf_istall_cnt + 32'd1 : perf_istall_cnt;
      end
   end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a memory responder and shadow model
module tb_mem_arbiter;
   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic clk = 1'b0, reset;
   logic if_req, dm_req, dm_we, mem_req, mem_we, mem_ack, if_stall, dm_stall;
   logic [1:0] dm_ls;
   logic [3:0] mem_be;
   logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0, errors = 0;
   int lat, wait_n, n, nreq;
   bit in_txn;
   txn_t cur, log_q[$], exp_q[$];
   logic [31:0] mem_m [256];
   logic [31:0] ref_m [256];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_ls(dm_ls), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // memory responder for the current cycle: logs each new bus request, checks it holds, acks after lat cycles
   task automatic mem_cycle();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !in_txn) begin
         in_txn = 1'b1;
         cur = '{mem_we, mem_be, mem_addr, mem_wdata};
         log_q.push_back(cur);
         wait_n = lat < 0 ? int'($urandom_range(0, 3)) : lat;
      end else if (in_txn) begin
         chk("hold_req", {31'd0, mem_req}, 32'd1);
         chk("hold_addr", mem_addr, cur.addr);
         chk("hold_be", {28'd0, mem_be}, {28'd0, cur.be});
      end else begin
         mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (in_txn) begin
         if (wait_n == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_m[cur.addr[9:2]];
            if (cur.we)
               for (int b = 0; b < 4; b++)
                  if (cur.be[b]) mem_m[cur.addr[9:2]][8*b +: 8] = cur.wdata[8*b +: 8];
            in_txn = 1'b0;
         end else begin
            wait_n--;
         end
      end
   endtask

   task automatic store_chk(input logic [1:0] ls, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be_e, input logic [31:0] wd_e, input logic [31:0] a_e);
      lat = 0;
      dm_req = 1'b1; dm_we = 1'b1; dm_ls = ls; dm_addr = a; dm_wdata = d;
      #1;
      mem_cycle(); step();
      chk("st_be", {28'd0, mem_be}, {28'd0, be_e});
      chk("st_wdata", mem_wdata, wd_e);
      chk("st_addr", mem_addr, a_e);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      mem_cycle(); step();
      mem_ack = 1'b0;
      chk("st_done", {31'd0, dm_stall}, 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      step();
   endtask

   initial begin
      logic dr, ir, we;
      logic [1:0] ls;
      logic [3:0] be_e;
      logic [31:0] da, dw, ia, wd_e, exp_drd, exp_ird;
      for (int i = 0; i < 256; i++) mem_m[i] = (i * 32'h0100_0193) ^ 32'hC0DE_0000;
      mem_m[16] = 32'h2010_0005;
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_ls = 0; dm_addr = 0; dm_wdata = 0;
      mem_ack = 0; mem_rdata = 0; lat = 0; in_txn = 0; reset = 1'b1;
      #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      step(); reset = 1'b0; step();

      // fetch only, two wait cycles
      lat = 2; if_req = 1'b1; if_addr = 32'h40; #1;
      n = 0; nreq = 0;
      while (if_stall && n < 20) begin
         if (mem_req) begin
            nreq++;
            chk("f_addr", mem_addr, 32'h40);
            chk("f_be", {28'd0, mem_be}, 32'hF);
            chk("f_we", {31'd0, mem_we}, 32'd0);
         end
         mem_cycle(); step(); n++;
      end
      mem_ack = 1'b0;
      chk("f_req_cycles", nreq, 3);
      chk("f_stall_cycles", n, 4);
      chk("f_rdata", if_rdata, 32'h2010_0005);
      if_req = 1'b0; step();

      // simultaneous load and fetch, zero-wait memory
      lat = 0; dm_req = 1'b1; dm_we = 1'b0; dm_ls = 2'b00; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44; #1;
      chk("b0_dstall", {31'd0, dm_stall}, 32'd1);
      chk("b0_istall", {31'd0, if_stall}, 32'd1);
      chk("b0_req", {31'd0, mem_req}, 32'd0);
      mem_cycle(); step();
      chk("b1_req", {31'd0, mem_req}, 32'd1);
      chk("b1_addr", mem_addr, 32'h100);
      chk("b1_dstall", {31'd0, dm_stall}, 32'd1);
      mem_cycle(); step();
      chk("b2_addr", mem_addr, 32'h44);
      chk("b2_dstall", {31'd0, dm_stall}, 32'd0);
      chk("b2_istall", {31'd0, if_stall}, 32'd1);
      chk("b2_drdata", dm_rdata, mem_m[64]);
      mem_cycle(); step();
      mem_ack = 1'b0;
      chk("b3_dstall", {31'd0, dm_stall}, 32'd0);
      chk("b3_istall", {31'd0, if_stall}, 32'd0);
      chk("b3_req", {31'd0, mem_req}, 32'd0);
      chk("b3_irdata", if_rdata, mem_m[17]);
      step();
      chk("b4_dclear", {31'd0, dm_stall}, 32'd1);
      chk("b4_iclear", {31'd0, if_stall}, 32'd1);
      dm_req = 1'b0; if_req = 1'b0; step();

      store_chk(2'b10, 32'h203, 32'hAB, 4'b1000, 32'hABAB_ABAB, 32'h200);
      store_chk(2'b01, 32'h12, 32'hBEEF, 4'b1100, 32'hBEEF_BEEF, 32'h10);

      // reset while a data access waits for its ack
      lat = 5; dm_req = 1'b1; dm_ls = 2'b00; dm_addr = 32'h300; #1;
      mem_cycle(); step();
      mem_cycle(); step();
      reset = 1'b1; #1;
      chk("rs_req", {31'd0, mem_req}, 32'd0);
      chk("rs_addr", mem_addr, 32'd0);
      chk("rs_be", {28'd0, mem_be}, 32'd0);
      chk("rs_wdata", mem_wdata, 32'd0);
      chk("rs_if_rdata", if_rdata, 32'd0);
      in_txn = 1'b0; mem_ack = 1'b0;
      step(); reset = 1'b0; lat = 0; #1;
      chk("rs_stall", {31'd0, dm_stall}, 32'd1);
      mem_cycle(); step();
      chk("rs_regrant", {31'd0, mem_req}, 32'd1);
      chk("rs_regrant_addr", mem_addr, 32'h300);
      mem_cycle(); step();
      mem_ack = 1'b0;
      chk("rs_done", {31'd0, dm_stall}, 32'd0);
      chk("rs_rdata", dm_rdata, mem_m[192]);
      dm_req = 1'b0; step();

      // data request withdrawn mid-transaction
      lat = 3; log_q.delete(); dm_req = 1'b1; dm_addr = 32'h80; #1;
      mem_cycle(); step();
      mem_cycle();
      dm_req = 1'b0; #1;
      chk("dr_stall", {31'd0, dm_stall}, 32'd0);
      step();
      repeat (8) begin mem_cycle(); step(); end
      mem_ack = 1'b0;
      chk("dr_ntxn", log_q.size(), 1);
      chk("dr_req", {31'd0, mem_req}, 32'd0);
      chk("dr_rdata", dm_rdata, mem_m[32]);
      dm_req = 1'b1; dm_addr = 32'h84; #1;
      chk("dr_cleared", {31'd0, dm_stall}, 32'd1);
      dm_req = 1'b0; step();

      // randomized pipeline traffic against a shadow memory
      ref_m = mem_m; lat = -1;
      for (int it = 0; it < 60; it++) begin
         dr = ($urandom_range(0, 3) != 0); ir = ($urandom_range(0, 3) != 0);
         we = 1'($urandom_range(0, 1)); ls = 2'($urandom_range(0, 3));
         da = $urandom_range(0, 1023); dw = $urandom; ia = $urandom_range(0, 255) * 4;
         exp_q.delete(); log_q.delete();
         be_e = ls == 2'b01 ? (da[1] ? 4'b1100 : 4'b0011) : ls == 2'b10 ? 4'(1 << da[1:0]) : 4'b1111;
         wd_e = ls == 2'b01 ? {2{dw[15:0]}} : ls == 2'b10 ? {4{dw[7:0]}} : dw;
         exp_drd = ref_m[da[9:2]];
         if (dr) begin
            exp_q.push_back('{we, be_e, da & 32'hFFFF_FFFC, wd_e});
            if (we)
               for (int b = 0; b < 4; b++)
                  if (be_e[b]) ref_m[da[9:2]][8*b +: 8] = wd_e[8*b +: 8];
         end
         exp_ird = ref_m[ia[9:2]];
         if (ir) exp_q.push_back('{1'b0, 4'b1111, ia, 32'd0});
         dm_req = dr; dm_we = we; dm_ls = ls; dm_addr = da; dm_wdata = dw; if_req = ir; if_addr = ia;
         #1;
         n = 0;
         while ((dm_stall || if_stall) && n < 40) begin mem_cycle(); step(); n++; end
         mem_ack = 1'b0;
         chk("r_timeout", {31'd0, n >= 40}, 32'd0);
         chk("r_ntxn", log_q.size(), exp_q.size());
         for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            chk("r_we", {31'd0, log_q[k].we}, {31'd0, exp_q[k].we});
            chk("r_be", {28'd0, log_q[k].be}, {28'd0, exp_q[k].be});
            chk("r_addr", log_q[k].addr, exp_q[k].addr);
            if (exp_q[k].we) chk("r_wdata", log_q[k].wdata, exp_q[k].wdata);
         end
         if (dr && !we) chk("r_drdata", dm_rdata, exp_drd);
         if (ir) chk("r_irdata", if_rdata, exp_ird);
         step();
      end
      dm_req = 1'b0; if_req = 1'b0; step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
